exe_stage_muldiv: RTL and testbench
===================================

Name: exe_stage_muldiv

Overview:
- Execute stage of the MIPS pipeline. Consumes the ID/EX pipeline register outputs and produces the EX/MEM pipeline register contents.
- Single-cycle ALU ops and branch resolution complete in one cycle.
- MUL/DIV/REM use an iterative shift-add / restoring-divide engine. The engine asserts `freeze` back to the ID/EX register and inserts bubbles downstream until the result is ready.

Parameters:
- WIDTH, 32: datapath width; iteration count equals WIDTH.
- DEST_W, 5: destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abort current op; EX/MEM loads bubble
- Dest_in  in  DEST_W  destination register
- Val1_in  in  WIDTH  operand 1
- Val2_in  in  WIDTH  operand 2 / sign-extended word offset
- Reg2_in  in  WIDTH  store data / BNE compare operand
- PC_in  in  WIDTH  PC+4 of instruction
- Br_type_in  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- EXE_CMD_in  in  4  ALU command
- MEM_R_EN_in, MEM_W_EN_in, WB_EN_in  in  1 each  control
- freeze  out  1  hold ID/EX and earlier stages
- Br_taken  out  1  branch taken (combinational)
- Br_addr  out  WIDTH  branch target (combinational)
- ALU_result  out  WIDTH  registered result
- Reg2  out  WIDTH  registered store data
- Dest  out  DEST_W  registered
- MEM_R_EN, MEM_W_EN, WB_EN  out  1 each  registered

Behaviour:
- Reset (clk edge with rst=1):
  - State goes to IDLE and the counter clears.
  - All registered outputs go to 0.
  - freeze=0 while rst=1.
  - Reset mid-operation discards the operation.
- EXE_CMD encoding:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLA, 1001 SLL, 1010 SRA, 1011 SRL. Shift amount is Val2[4:0].
  - 1100 MUL (low WIDTH bits of product).
  - 1101 DIV (signed quotient), 1110 REM (signed remainder), 1111 NOP (result 0).
  - Unlisted codes behave as NOP.
- Single-cycle ops: in IDLE the EX/MEM register loads result and control at the next edge (latency 1).
- States:
  - IDLE to MUL when EXE_CMD=1100 and flush=0.
  - IDLE to DIV when EXE_CMD is 1101 or 1110 and flush=0.
  - MUL/DIV to DONE after WIDTH iterations.
  - DONE to IDLE unconditionally.
- Entering MUL or DIV latches operands and all control inputs; the counter starts at 0.
- MUL/DIV arithmetic:
  - Both operate on magnitudes; the sign is fixed in DONE.
  - MUL iterates one bit per cycle.
  - DIV is restoring, one quotient bit per cycle. Remainder takes the dividend's sign.
- freeze:
  - =1 combinationally in IDLE when the incoming cmd is MUL/DIV/REM and flush=0.
  - =1 throughout MUL/DIV.
  - =0 in DONE, so ID/EX advances at the DONE edge.
- While in MUL/DIV, the EX/MEM register loads a bubble every cycle (all controls 0, data 0).
- In DONE the EX/MEM register loads the final result with the latched Dest/Reg2/controls.
- Total latency from issue edge to result visible is WIDTH+2 cycles (34). freeze stays high WIDTH+1 cycles.
- Divide by zero: quotient = all ones, remainder = dividend.
- Overflow case (most-negative / −1): quotient = most-negative, remainder = 0.
- Branch:
  - Br_addr = PC_in + (Val2_in << 2).
  - Taken conditions: BEZ when Val1_in==0; BNE when Val1_in!=Reg2_in; JMP always.
  - Br_taken is forced 0 when not in IDLE or when freeze=1.
- flush:
  - In any state, the EX/MEM register loads a bubble and the state goes to IDLE.
  - flush has priority over starting or finishing an op.
  - Simultaneous rst and flush: reset wins.

Test Plan:
- Reset, then ADD Val1=5, Val2=7, WB_EN=1, Dest=3 → next cycle ALU_result=12, WB_EN=1, Dest=3, freeze never high.
- MUL 6 × 0xFFFFFFF9 →
  - freeze high 33 cycles and WB_EN=0 during busy.
  - ALU_result=0xFFFFFFD6 with WB_EN=1 at cycle 34.
  - Next instruction (ADD) completes 1 cycle later.
- DIV 0xFFFFFFF9 / 2 → quotient 0xFFFFFFFD. REM on same operands → 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM gives 0.
- DIV 10/0 → 0xFFFFFFFF, and REM gives 10.
- BNE Val1=3, Reg2=4, PC_in=0x100, Val2=4 → Br_taken=1, Br_addr=0x110. Same with Val1=4 → Br_taken=0.
- Start MUL, assert flush at busy cycle 10 → next cycle IDLE, freeze=0, bubble output.
- Repeat with rst instead of flush → all outputs 0.

Source files
------------

// File: rtl/exe_stage_muldiv.sv
// rtl/exe_stage_muldiv.sv - MIPS execute stage with single-cycle ALU, branch resolution and iterative MUL/DIV/REM
module exe_stage_muldiv #(
    parameter int WIDTH  = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DEST_W-1:0] Dest_in,
    input  logic [WIDTH-1:0]  Val1_in,
    input  logic [WIDTH-1:0]  Val2_in,
    input  logic [WIDTH-1:0]  Reg2_in,
    input  logic [WIDTH-1:0]  PC_in,
    input  logic [1:0]        Br_type_in,
    input  logic [3:0]        EXE_CMD_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              WB_EN_in,
    output logic              freeze,
    output logic              Br_taken,
    output logic [WIDTH-1:0]  Br_addr,
    output logic [WIDTH-1:0]  ALU_result,
    output logic [WIDTH-1:0]  Reg2,
    output logic [DEST_W-1:0] Dest,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic              WB_EN
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // acc: running product (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0]  acc_q, acc_d;
    // opa: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV)
    logic [WIDTH-1:0]  opa_q, opa_d;
    // opb: multiplier (MUL) or divisor (DIV)
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  dividend_q, dividend_d;
    logic              is_mul_q, is_mul_d;
    logic              is_rem_q, is_rem_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div_zero_q, div_zero_d;
    logic [DEST_W-1:0] dest_lat_q, dest_lat_d;
    logic [WIDTH-1:0]  reg2_lat_q, reg2_lat_d;
    logic              mr_lat_q, mr_lat_d;
    logic              mw_lat_q, mw_lat_d;
    logic              wb_lat_q, wb_lat_d;

    logic [WIDTH-1:0]  alu_result_q, alu_result_d;
    logic [WIDTH-1:0]  reg2_q, reg2_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic              mem_r_q, mem_r_d;
    logic              mem_w_q, mem_w_d;
    logic              wb_q, wb_d;

    logic              is_mul_cmd, is_div_cmd, long_cmd, busy, br_cond;
    logic [4:0]        shamt;
    logic [WIDTH-1:0]  alu_res, abs_a, abs_b, final_res;
    logic [WIDTH:0]    div_tmp, div_sub;

    assign is_mul_cmd = (EXE_CMD_in == 4'b1100);
    assign is_div_cmd = (EXE_CMD_in == 4'b1101) || (EXE_CMD_in == 4'b1110);
    assign long_cmd   = is_mul_cmd || is_div_cmd;
    assign busy       = (state_q == S_MUL) || (state_q == S_DIV);
    assign shamt      = Val2_in[4:0];
    assign abs_a      = Val1_in[WIDTH-1] ? -Val1_in : Val1_in;
    assign abs_b      = Val2_in[WIDTH-1] ? -Val2_in : Val2_in;
    assign div_tmp    = {acc_q, opa_q[WIDTH-1]};
    assign div_sub    = div_tmp - {1'b0, opb_q};

    assign freeze   = !rst && (busy || ((state_q == S_IDLE) && long_cmd && !flush));
    assign Br_addr  = PC_in + (Val2_in << 2);
    assign Br_taken = br_cond && (state_q == S_IDLE) && !freeze;

    always_comb begin
        br_cond = 1'b0;
        case (Br_type_in)
            2'b01:   br_cond = (Val1_in == '0);
            2'b10:   br_cond = (Val1_in != Reg2_in);
            2'b11:   br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (EXE_CMD_in)
            4'b0000: alu_res = Val1_in + Val2_in;
            4'b0010: alu_res = Val1_in - Val2_in;
            4'b0100: alu_res = Val1_in & Val2_in;
            4'b0101: alu_res = Val1_in | Val2_in;
            4'b0110: alu_res = ~(Val1_in | Val2_in);
            4'b0111: alu_res = Val1_in ^ Val2_in;
            4'b1000: alu_res = Val1_in << shamt;
            4'b1001: alu_res = Val1_in << shamt;
            4'b1010: alu_res = WIDTH'($signed(Val1_in) >>> shamt);
            4'b1011: alu_res = Val1_in >> shamt;
            default: alu_res = '0;
        endcase
    end

    // Sign correction of the magnitude result, plus the divide-by-zero convention
    always_comb begin
        final_res = '0;
        if (is_mul_q)        final_res = neg_res_q ? -acc_q : acc_q;
        else if (div_zero_q) final_res = is_rem_q ? dividend_q : '1;
        else if (is_rem_q)   final_res = neg_rem_q ? -acc_q : acc_q;
        else                 final_res = neg_res_q ? -opa_q : opa_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        dividend_d   = dividend_q;
        is_mul_d     = is_mul_q;
        is_rem_d     = is_rem_q;
        neg_res_d    = neg_res_q;
        neg_rem_d    = neg_rem_q;
        div_zero_d   = div_zero_q;
        dest_lat_d   = dest_lat_q;
        reg2_lat_d   = reg2_lat_q;
        mr_lat_d     = mr_lat_q;
        mw_lat_d     = mw_lat_q;
        wb_lat_d     = wb_lat_q;
        alu_result_d = '0;
        reg2_d       = '0;
        dest_d       = '0;
        mem_r_d      = 1'b0;
        mem_w_d      = 1'b0;
        wb_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (long_cmd) begin
                    state_d    = is_mul_cmd ? S_MUL : S_DIV;
                    cnt_d      = '0;
                    acc_d      = '0;
                    opa_d      = abs_a;
                    opb_d      = abs_b;
                    dividend_d = Val1_in;
                    is_mul_d   = is_mul_cmd;
                    is_rem_d   = (EXE_CMD_in == 4'b1110);
                    neg_res_d  = Val1_in[WIDTH-1] ^ Val2_in[WIDTH-1];
                    neg_rem_d  = Val1_in[WIDTH-1];
                    div_zero_d = (Val2_in == '0);
                    dest_lat_d = Dest_in;
                    reg2_lat_d = Reg2_in;
                    mr_lat_d   = MEM_R_EN_in;
                    mw_lat_d   = MEM_W_EN_in;
                    wb_lat_d   = WB_EN_in;
                end else begin
                    alu_result_d = alu_res;
                    reg2_d       = Reg2_in;
                    dest_d       = Dest_in;
                    mem_r_d      = MEM_R_EN_in;
                    mem_w_d      = MEM_W_EN_in;
                    wb_d         = WB_EN_in;
                end
            end
            S_MUL: begin
                acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) state_d = S_DONE;
            end
            S_DIV: begin
                // Restore by simply not committing the subtraction when it borrows
                acc_d = div_sub[WIDTH] ? div_tmp[WIDTH-1:0] : div_sub[WIDTH-1:0];
                opa_d = {opa_q[WIDTH-2:0], ~div_sub[WIDTH]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) state_d = S_DONE;
            end
            S_DONE: begin
                state_d      = S_IDLE;
                alu_result_d = final_res;
                reg2_d       = reg2_lat_q;
                dest_d       = dest_lat_q;
                mem_r_d      = mr_lat_q;
                mem_w_d      = mw_lat_q;
                wb_d         = wb_lat_q;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d      = S_IDLE;
            alu_result_d = '0;
            reg2_d       = '0;
            dest_d       = '0;
            mem_r_d      = 1'b0;
            mem_w_d      = 1'b0;
            wb_d         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            dividend_q   <= '0;
            is_mul_q     <= 1'b0;
            is_rem_q     <= 1'b0;
            neg_res_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            div_zero_q   <= 1'b0;
            dest_lat_q   <= '0;
            reg2_lat_q   <= '0;
            mr_lat_q     <= 1'b0;
            mw_lat_q     <= 1'b0;
            wb_lat_q     <= 1'b0;
            alu_result_q <= '0;
            reg2_q       <= '0;
            dest_q       <= '0;
            mem_r_q      <= 1'b0;
            mem_w_q      <= 1'b0;
            wb_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            dividend_q   <= dividend_d;
            is_mul_q     <= is_mul_d;
            is_rem_q     <= is_rem_d;
            neg_res_q    <= neg_res_d;
            neg_rem_q    <= neg_rem_d;
            div_zero_q   <= div_zero_d;
            dest_lat_q   <= dest_lat_d;
            reg2_lat_q   <= reg2_lat_d;
            mr_lat_q     <= mr_lat_d;
            mw_lat_q     <= mw_lat_d;
            wb_lat_q     <= wb_lat_d;
            alu_result_q <= alu_result_d;
            reg2_q       <= reg2_d;
            dest_q       <= dest_d;
            mem_r_q      <= mem_r_d;
            mem_w_q      <= mem_w_d;
            wb_q         <= wb_d;
        end
    end

    assign ALU_result = alu_result_q;
    assign Reg2       = reg2_q;
    assign Dest       = dest_q;
    assign MEM_R_EN   = mem_r_q;
    assign MEM_W_EN   = mem_w_q;
    assign WB_EN      = wb_q;
endmodule

// File: tb/tb_exe_stage_muldiv.sv
// tb/tb_exe_stage_muldiv.sv - scoreboard bench for exe_stage_muldiv
module tb_exe_stage_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, flush;
    logic [4:0]   Dest_in;
    logic [W-1:0] Val1_in, Val2_in, Reg2_in, PC_in;
    logic [1:0]   Br_type_in;
    logic [3:0]   EXE_CMD_in;
    logic         MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
    logic         freeze, Br_taken;
    logic [W-1:0] Br_addr, ALU_result, Reg2;
    logic [4:0]   Dest;
    logic         MEM_R_EN, MEM_W_EN, WB_EN;

    exe_stage_muldiv #(.WIDTH(W), .DEST_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .Dest_in(Dest_in), .Val1_in(Val1_in), .Val2_in(Val2_in), .Reg2_in(Reg2_in),
        .PC_in(PC_in), .Br_type_in(Br_type_in), .EXE_CMD_in(EXE_CMD_in),
        .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
        .freeze(freeze), .Br_taken(Br_taken), .Br_addr(Br_addr),
        .ALU_result(ALU_result), .Reg2(Reg2), .Dest(Dest),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] reg2;
        logic [4:0]   dest;
        string        tag;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [W-1:0] v1, input logic [W-1:0] v2,
                         input logic [W-1:0] r2, input logic [4:0] dest, input logic wb);
        EXE_CMD_in  = cmd;
        Val1_in     = v1;
        Val2_in     = v2;
        Reg2_in     = r2;
        Dest_in     = dest;
        WB_EN_in    = wb;
        MEM_R_EN_in = 1'b0;
        MEM_W_EN_in = 1'b0;
        Br_type_in  = 2'b00;
        PC_in       = '0;
    endtask

    task automatic drive_nop();
        drive(4'hF, '0, '0, '0, 5'd0, 1'b0);
    endtask

    // Acts as the ID/EX register: holds the op while freeze is high, then advances to a NOP
    task automatic run_op(input string tag, input logic [3:0] cmd, input logic [W-1:0] v1,
                          input logic [W-1:0] v2, input logic [W-1:0] r2, input logic [4:0] dest,
                          input logic [W-1:0] exp_res, input int exp_lat, input int exp_frz);
        exp_t e;
        int   lat = 0;
        int   frz = 0;
        logic fz;
        bit   done = 0;
        drive(cmd, v1, v2, r2, dest, 1'b1);
        e.res = exp_res; e.reg2 = r2; e.dest = dest; e.tag = tag;
        sb.push_back(e);
        while (!done && lat < 100) begin
            #1 fz = freeze;
            if (fz === 1'b1) frz++;
            @(negedge clk);
            lat++;
            if (WB_EN === 1'b1) begin
                e = sb.pop_front();
                check({e.tag, " result"}, ALU_result, e.res);
                check({e.tag, " dest"}, W'(Dest), W'(e.dest));
                check({e.tag, " reg2"}, Reg2, e.reg2);
                done = 1;
            end else if (lat == 1) begin
                check({tag, " bubble"}, ALU_result, '0);
            end
            if (!done && fz !== 1'b1) drive_nop();
        end
        if (!done) void'(sb.pop_front());
        check({tag, " latency"}, W'(lat), W'(exp_lat));
        check({tag, " freeze cycles"}, W'(frz), W'(exp_frz));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        drive(4'b1100, 32'd6, 32'd7, '0, 5'd1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        check("freeze during reset", W'(freeze), '0);
        check("reset ALU_result", ALU_result, '0);
        check("reset WB_EN", W'(WB_EN), '0);
        check("reset Dest", W'(Dest), '0);
        rst = 1'b0;
        drive_nop();
        @(negedge clk);

        run_op("add", 4'b0000, 32'd5, 32'd7, 32'h55, 5'd3, 32'd12, 1, 0);
        run_op("sub", 4'b0010, 32'd5, 32'd7, '0, 5'd4, 32'hFFFF_FFFE, 1, 0);
        run_op("nor", 4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0000, '0, 5'd5, 32'h0000_0F0F, 1, 0);
        run_op("sra", 4'b1010, 32'h8000_0000, 32'd4, '0, 5'd6, 32'hF800_0000, 1, 0);
        run_op("srl", 4'b1011, 32'h8000_0000, 32'd4, '0, 5'd6, 32'h0800_0000, 1, 0);
        run_op("sll", 4'b1001, 32'd1, 32'h0000_003F, '0, 5'd7, 32'h8000_0000, 1, 0);
        run_op("unlisted", 4'b0001, 32'd9, 32'd9, '0, 5'd8, 32'd0, 1, 0);

        run_op("mul", 4'b1100, 32'd6, 32'hFFFF_FFF9, 32'hAA, 5'd9, 32'hFFFF_FFD6, 34, 33);
        run_op("add after mul", 4'b0000, 32'd1, 32'd2, '0, 5'd10, 32'd3, 1, 0);
        run_op("div neg", 4'b1101, 32'hFFFF_FFF9, 32'd2, '0, 5'd11, 32'hFFFF_FFFD, 34, 33);
        run_op("rem neg", 4'b1110, 32'hFFFF_FFF9, 32'd2, '0, 5'd12, 32'hFFFF_FFFF, 34, 33);
        run_op("div ovf", 4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, '0, 5'd13, 32'h8000_0000, 34, 33);
        run_op("rem ovf", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, '0, 5'd14, 32'd0, 34, 33);
        run_op("div zero", 4'b1101, 32'd10, 32'd0, '0, 5'd15, 32'hFFFF_FFFF, 34, 33);
        run_op("rem zero", 4'b1110, 32'd10, 32'd0, '0, 5'd16, 32'd10, 34, 33);
        run_op("div pos", 4'b1101, 32'd100, 32'd7, '0, 5'd17, 32'd14, 34, 33);

        drive_nop();
        Br_type_in = 2'b10; Val1_in = 32'd3; Reg2_in = 32'd4; PC_in = 32'h100; Val2_in = 32'd4;
        #1;
        check("bne taken", W'(Br_taken), 32'd1);
        check("bne addr", Br_addr, 32'h110);
        Val1_in = 32'd4;
        #1;
        check("bne not taken", W'(Br_taken), 32'd0);
        Br_type_in = 2'b01; Val1_in = 32'd0;
        #1;
        check("bez taken", W'(Br_taken), 32'd1);
        @(negedge clk);

        drive(4'b1100, 32'd3, 32'd5, '0, 5'd18, 1'b1);
        Br_type_in = 2'b11;
        #1;
        check("flush issue freeze", W'(freeze), 32'd1);
        check("jmp gated by freeze", W'(Br_taken), 32'd0);
        repeat (10) @(negedge clk);
        check("jmp gated while busy", W'(Br_taken), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive_nop();
        #1;
        check("flush freeze", W'(freeze), 32'd0);
        check("flush WB_EN", W'(WB_EN), 32'd0);
        check("flush ALU_result", ALU_result, '0);
        @(negedge clk);
        run_op("add after flush", 4'b0000, 32'd20, 32'd22, '0, 5'd19, 32'd42, 1, 0);

        drive(4'b1100, 32'd3, 32'd5, '0, 5'd20, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst busy freeze", W'(freeze), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_nop();
        #1;
        check("after rst freeze", W'(freeze), 32'd0);
        check("after rst WB_EN", W'(WB_EN), 32'd0);
        @(negedge clk);
        run_op("add after rst", 4'b0000, 32'd9, 32'd9, 32'h77, 5'd21, 32'd18, 1, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst clears ALU_result", ALU_result, '0);
        check("rst clears WB_EN", W'(WB_EN), '0);
        check("rst clears Reg2", Reg2, '0);
        rst = 1'b0;
        drive_nop();
        @(negedge clk);

        check("scoreboard empty", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
